// File: rtl/cnn_pkg.sv
// Shared constants, types and helpers for the
// digit-recognition CNN datapath.
package cnn_pkg;

  localparam int DATA_W   = 16;
  localparam int IN_DIM   = 24;
  localparam int CHANNELS = 2;

  localparam int HALF   = IN_DIM / 2;
  localparam int N_WIN  = CHANNELS * HALF * HALF;
  localparam int IN_AW  = $clog2(CHANNELS * IN_DIM * IN_DIM);
  localparam int OUT_AW = $clog2(N_WIN);
  localparam int POS_W  = $clog2(HALF);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic signed [DATA_W-1:0] act_t;

  function automatic act_t smax(act_t a, act_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool1_engine_if.sv
// Control, conv1 read and P1 write bundle
// of the layer-1 max-pool engine.
interface pool1_engine_if;
  import cnn_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [IN_AW-1:0]  rd_addr0;
  logic [IN_AW-1:0]  rd_addr1;
  logic [IN_AW-1:0]  rd_addr2;
  logic [IN_AW-1:0]  rd_addr3;
  act_t              rd_data0;
  act_t              rd_data1;
  act_t              rd_data2;
  act_t              rd_data3;
  logic              wr_en;
  logic [OUT_AW-1:0] wr_addr;
  act_t              wr_data;

  modport master (
    input  start,
    input  rd_data0, rd_data1,
    input  rd_data2, rd_data3,
    output busy, done, rd_en,
    output rd_addr0, rd_addr1,
    output rd_addr2, rd_addr3,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output start,
    output rd_data0, rd_data1,
    output rd_data2, rd_data3,
    input  busy, done, rd_en,
    input  rd_addr0, rd_addr1,
    input  rd_addr2, rd_addr3,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/pool1_addr_gen.sv
// 2x2 window walker: channel/row/column counters
// and the four conv1 read addresses per window.
module pool1_addr_gen
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [IN_AW-1:0] addr0,
  output logic [IN_AW-1:0] addr1,
  output logic [IN_AW-1:0] addr2,
  output logic [IN_AW-1:0] addr3,
  output logic             last
);

  logic [POS_W-1:0] col;
  logic [POS_W-1:0] row;
  logic [CH_W-1:0]  ch;
  logic [IN_AW-1:0] base;
  logic             col_end;
  logic             row_end;
  logic             ch_end;

  assign col_end = (col == POS_W'(HALF - 1));
  assign row_end = (row == POS_W'(HALF - 1));
  assign ch_end  = (ch == CH_W'(CHANNELS - 1));
  assign last    = col_end & row_end & ch_end;

  // Addresses read as zero whenever no window is issued.
  assign addr0 = en ? base : '0;
  assign addr1 = en ? base + IN_AW'(1) : '0;
  assign addr2 = en ? base + IN_AW'(IN_DIM) : '0;
  assign addr3 = en ? base + IN_AW'(IN_DIM + 1) : '0;

  // Step one window; row wrap skips the odd row and map end runs on contiguously.
  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      col  <= '0;
      row  <= '0;
      ch   <= '0;
      base <= '0;
    end else if (col_end) begin
      col  <= '0;
      base <= base + IN_AW'(IN_DIM + 2);
      if (row_end) begin
        row <= '0;
        ch  <= ch + 1'b1;
      end else begin
        row <= row + 1'b1;
      end
    end else begin
      col  <= col + 1'b1;
      base <= base + IN_AW'(2);
    end
  end

endmodule

// File: rtl/pool1_engine.sv
// Layer-1 2x2/stride-2 max-pool engine, one window
// per cycle through a fixed 3-stage pipeline.
module pool1_engine
  import cnn_pkg::*;
#(
  parameter int RELU = 1
) (
  input logic            clk,
  input logic            reset,
  pool1_engine_if.master bus
);

  state_t            state;
  state_t            state_nx;
  logic              run;
  logic              last;
  logic              v1;
  logic              wr_en;
  logic [OUT_AW-1:0] wr_addr;
  act_t              wr_data;
  act_t              m01;
  act_t              m23;
  act_t              mx;
  act_t              res;

  assign run       = (state == RUN);
  assign bus.rd_en = run;
  assign bus.busy  = run | (state == DRAIN);
  assign bus.done  = (state == DONE);
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;

  pool1_addr_gen u_addr (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .addr0 (bus.rd_addr0),
    .addr1 (bus.rd_addr1),
    .addr2 (bus.rd_addr2),
    .addr3 (bus.rd_addr3),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; DRAIN ends once the read stage holds no data.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = RUN;
      RUN:   if (last) state_nx = DRAIN;
      DRAIN: if (!v1) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Signed max tree with optional clamp on the returned window.
  always_comb begin
    m01 = smax(bus.rd_data0, bus.rd_data1);
    m23 = smax(bus.rd_data2, bus.rd_data3);
    mx  = smax(m01, m23);
    res = mx;
    if (RELU != 0 && mx[DATA_W-1]) res = '0;
  end

  // Data-valid pipeline, result register and linear P1 address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1      <= 1'b0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
    end else begin
      v1    <= run;
      wr_en <= v1;
      if (v1) wr_data <= res;
      if (state == IDLE && bus.start)
        wr_addr <= '0;
      else if (wr_en)
        wr_addr <= wr_addr + OUT_AW'(1);
    end
  end

endmodule

// File: tb/tb_pool1_engine.sv
// Randomised and directed bench for pool1_engine
// against a window-level reference model.
module tb_pool1_engine;
  import cnn_pkg::*;

  localparam int D  = 24;
  localparam int H  = 12;
  localparam int NW = 288;
  localparam int MW = 1152;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;

  pool1_engine_if b1 ();
  pool1_engine_if b0 ();

  assign b1.start = start;
  assign b0.start = start;

  pool1_engine #(.RELU(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  pool1_engine #(.RELU(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  always #5 clk = ~clk;

  logic signed [15:0] mem [0:MW-1];
  int exp_raw [0:NW-1];
  int p1 [2][0:NW-1];
  int rda [4][0:NW-1];
  int wcount [2];
  int done_at;
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int cyc0 = 0;
  int abort_t = 0;
  bit active = 1'b0;

  always @(posedge clk) cnt <= cnt + 1;

  function automatic logic signed [15:0] rdm(input int a);
    if (a >= 0 && a < MW) return mem[a];
    return '0;
  endfunction

  // Conv1 memory: one-cycle read latency on each port of each instance.
  always @(posedge clk) begin
    if (b1.rd_en) begin
      b1.rd_data0 <= rdm(int'(b1.rd_addr0));
      b1.rd_data1 <= rdm(int'(b1.rd_addr1));
      b1.rd_data2 <= rdm(int'(b1.rd_addr2));
      b1.rd_data3 <= rdm(int'(b1.rd_addr3));
    end
    if (b0.rd_en) begin
      b0.rd_data0 <= rdm(int'(b0.rd_addr0));
      b0.rd_data1 <= rdm(int'(b0.rd_addr1));
      b0.rd_data2 <= rdm(int'(b0.rd_addr2));
      b0.rd_data3 <= rdm(int'(b0.rd_addr3));
    end
  end

  function automatic int wbase(input int w);
    int c, r, k;
    c = w / (H * H);
    r = (w % (H * H)) / H;
    k = w % H;
    return c * D * D + 2 * r * D + 2 * k;
  endfunction

  task automatic build_model();
    for (int w = 0; w < NW; w++) begin
      int b, m;
      b = wbase(w);
      m = mem[b];
      if (mem[b + 1] > m) m = mem[b + 1];
      if (mem[b + D] > m) m = mem[b + D];
      if (mem[b + D + 1] > m) m = mem[b + D + 1];
      exp_raw[w] = m;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc_check(
    input int d, input int t,
    input int rd_en, input int busy, input int done,
    input int a0, input int a1, input int a2, input int a3,
    input int wen, input int wa, input int wd
  );
    string s;
    s = $sformatf("dut%0d t%0d", d, t);
    if (abort_t > 0 && t > abort_t) begin
      if (t <= abort_t + 3) begin
        chk({s, " rst rd_en"}, rd_en, 0);
        chk({s, " rst busy"}, busy, 0);
        chk({s, " rst done"}, done, 0);
        chk({s, " rst wr_en"}, wen, 0);
        chk({s, " rst addr"}, a0 | a1 | a2 | a3, 0);
        chk({s, " rst wr_addr"}, wa, 0);
        chk({s, " rst wr_data"}, wd, 0);
      end
    end else if (t >= 1 && t <= NW + 4) begin
      int e_rd, e_wr, e_busy, e_done;
      e_rd   = (t <= NW) ? 1 : 0;
      e_wr   = (t >= 3 && t <= NW + 2) ? 1 : 0;
      e_busy = (t <= NW + 2) ? 1 : 0;
      e_done = (t == NW + 3) ? 1 : 0;
      chk({s, " rd_en"}, rd_en, e_rd);
      chk({s, " wr_en"}, wen, e_wr);
      chk({s, " busy"}, busy, e_busy);
      chk({s, " done"}, done, e_done);
      if (e_rd == 1 && rd_en == 1) begin
        int b;
        b = wbase(t - 1);
        chk({s, " rd_addr0"}, a0, b);
        chk({s, " rd_addr1"}, a1, b + 1);
        chk({s, " rd_addr2"}, a2, b + D);
        chk({s, " rd_addr3"}, a3, b + D + 1);
        if (d == 1) begin
          rda[0][t-1] = a0;
          rda[1][t-1] = a1;
          rda[2][t-1] = a2;
          rda[3][t-1] = a3;
        end
      end
      if (e_wr == 1 && wen == 1) begin
        int w, e;
        w = t - 3;
        e = exp_raw[w];
        if (d == 1 && e < 0) e = 0;
        chk({s, " wr_addr"}, wa, w);
        chk({s, " wr_data"}, wd, e);
      end
      if (wen == 1) begin
        if (wa < NW) p1[d][wa] = wd;
        wcount[d]++;
      end
      if (done == 1 && d == 1) done_at = t;
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (active) begin
      int t;
      t = cnt - cyc0;
      cyc_check(1, t, int'(b1.rd_en), int'(b1.busy),
        int'(b1.done), int'(b1.rd_addr0), int'(b1.rd_addr1),
        int'(b1.rd_addr2), int'(b1.rd_addr3), int'(b1.wr_en),
        int'(b1.wr_addr), int'(b1.wr_data));
      cyc_check(0, t, int'(b0.rd_en), int'(b0.busy),
        int'(b0.done), int'(b0.rd_addr0), int'(b0.rd_addr1),
        int'(b0.rd_addr2), int'(b0.rd_addr3), int'(b0.wr_en),
        int'(b0.wr_addr), int'(b0.wr_data));
    end
  end

  task automatic run(input bit stress, input int abort_at);
    int last_t;
    build_model();
    wcount[0] = 0;
    wcount[1] = 0;
    done_at = 0;
    @(negedge clk);
    start = 1'b1;
    cyc0 = cnt;
    abort_t = abort_at;
    active = 1'b1;
    last_t = (abort_at > 0) ? abort_at + 3 : NW + 3;
    for (int t = 1; t <= last_t; t++) begin
      @(negedge clk);
      start = stress && (t == 5 || t == NW + 3);
      reset = !(abort_at > 0 && t == abort_at);
    end
    if (abort_at > 0) active = 1'b0;
  endtask

  task automatic set_win(input int w, input int v0, input int v1,
                         input int v2, input int v3);
    int b;
    b = wbase(w);
    mem[b]         = 16'(v0);
    mem[b + 1]     = 16'(v1);
    mem[b + D]     = 16'(v2);
    mem[b + D + 1] = 16'(v3);
  endtask

  task automatic reset_zero_check(input string s);
    chk({s, " busy"}, int'(b1.busy) | int'(b0.busy), 0);
    chk({s, " done"}, int'(b1.done) | int'(b0.done), 0);
    chk({s, " rd_en"}, int'(b1.rd_en) | int'(b0.rd_en), 0);
    chk({s, " wr_en"}, int'(b1.wr_en) | int'(b0.wr_en), 0);
    chk({s, " rd_addr"}, int'(b1.rd_addr0 | b1.rd_addr1 |
        b1.rd_addr2 | b1.rd_addr3), 0);
    chk({s, " wr_addr"}, int'(b1.wr_addr) | int'(b0.wr_addr), 0);
    chk({s, " wr_data"}, int'(b1.wr_data) | int'(b0.wr_data), 0);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = 16'(i);
    repeat (3) @(posedge clk);
    #1;
    reset_zero_check("reset");
    @(negedge clk);
    reset = 1'b1;

    build_model();
    chk("model w0", exp_raw[0], 25);
    chk("model w144", exp_raw[144], 601);

    run(1'b1, 0);
    chk("ramp p1[0]", p1[1][0], 25);
    chk("ramp p1[1]", p1[1][1], 27);
    chk("ramp p1[12]", p1[1][12], 73);
    chk("ramp p1[144]", p1[1][144], 601);
    chk("ramp writes", wcount[1], 288);
    chk("ramp done cycle", done_at, 291);
    chk("w0 a0", rda[0][0], 0);
    chk("w0 a1", rda[1][0], 1);
    chk("w0 a2", rda[2][0], 24);
    chk("w0 a3", rda[3][0], 25);
    chk("w12 a0", rda[0][12], 48);
    chk("w12 a3", rda[3][12], 73);
    chk("w144 a0", rda[0][144], 576);
    chk("w287 a3", rda[3][287], 1151);

    run(1'b0, 0);
    chk("rerun writes", wcount[0], 288);

    run(1'b0, 100);
    run(1'b0, 0);
    chk("post-reset writes", wcount[1], 288);
    chk("post-reset p1[0]", p1[1][0], 25);

    for (int w = 0; w < NW; w++) begin
      case (w % 4)
        0: set_win(w, 100, -5, -5, -5);
        1: set_win(w, -5, 100, -5, -5);
        2: set_win(w, -5, -5, 100, -5);
        default: set_win(w, -5, -5, -5, 100);
      endcase
    end
    set_win(5, -3, -7, -1, -9);
    set_win(6, -32768, 32767, 32767, 0);
    set_win(7, -32768, -32768, -32768, -32768);
    run(1'b0, 0);
    chk("peak d0", p1[1][0], 100);
    chk("peak d3", p1[0][3], 100);
    chk("neg relu", p1[1][5], 0);
    chk("neg raw", p1[0][5], -1);
    chk("tie max", p1[1][6], 32767);
    chk("min raw", p1[0][7], -32768);
    chk("min relu", p1[1][7], 0);

    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < MW; i++) mem[i] = 16'($urandom);
      run(1'b0, 0);
      chk("rand writes", wcount[0], 288);
    end

    start = 1'b0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
